lab7bonus_top: RTL and testbench



---
 rtl/lab7bonus_top.sv | 222 ++++++++++++++++++++++
 tb/tb_lab7bonus_top.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/lab7bonus_top.sv
// lab7bonus_top: multi-cycle 16-bit CPU with 256x16 RAM, LED/switch I/O; HEX_DEBUG_EN shows R0 and PC on HEX.
module lab7bonus_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [2:0]  wnum_i,
  input  logic [15:0] wdata_i,
  input  logic [2:0]  ra_i,
  input  logic [2:0]  rb_i,
  input  logic [2:0]  rc_i,
  output logic [15:0] ra_o,
  output logic [15:0] rb_o,
  output logic [15:0] rc_o,
  output logic [15:0] r0_o
);
  logic [15:0] R0, R1, R2, R3, R4, R5, R6, R7;
  logic [7:0][15:0] r;
  assign r = {R7, R6, R5, R4, R3, R2, R1, R0};
  assign ra_o = r[ra_i];
  assign rb_o = r[rb_i];
  assign rc_o = r[rc_i];
  assign r0_o = R0;
  always_ff @(posedge clk) begin
    if (rst) {R7, R6, R5, R4, R3, R2, R1, R0} <= '0;
    else if (we_i)
      case (wnum_i)
        3'd0: R0 <= wdata_i;
        3'd1: R1 <= wdata_i;
        3'd2: R2 <= wdata_i;
        3'd3: R3 <= wdata_i;
        3'd4: R4 <= wdata_i;
        3'd5: R5 <= wdata_i;
        3'd6: R6 <= wdata_i;
        default: R7 <= wdata_i;
      endcase
  end
endmodule

module lab7bonus_dp (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir_i,
  input  logic        alu_en_i,
  input  logic        ld_en_i,
  input  logic        lnk_en_i,
  input  logic [15:0] ld_data_i,
  input  logic [8:0]  pc_i,
  output logic [15:0] rn_o,
  output logic [15:0] rd_o,
  output logic [15:0] r0_o,
  output logic        n_o,
  output logic        z_o,
  output logic        v_o
);
  logic [4:0]  opc;
  logic [15:0] rm, sh, dif, res, wdata;
  logic [2:0]  wnum;
  logic        wr_alu, n_q, z_q, v_q;
  assign opc = ir_i[15:11];
  lab7bonus_regfile REGFILE (
    .clk(clk), .rst(rst), .we_i(wr_alu | ld_en_i | lnk_en_i), .wnum_i(wnum), .wdata_i(wdata),
    .ra_i(ir_i[10:8]), .rb_i(ir_i[7:5]), .rc_i(ir_i[2:0]),
    .ra_o(rn_o), .rb_o(rd_o), .rc_o(rm), .r0_o(r0_o)
  );
  assign sh = ir_i[4:3] == 2'b01 ? {rm[14:0], 1'b0} :
              ir_i[4:3] == 2'b10 ? {1'b0, rm[15:1]} :
              ir_i[4:3] == 2'b11 ? {rm[15], rm[15:1]} : rm;
  assign dif = rn_o - sh;
  assign res = opc == 5'b11010 ? {{8{ir_i[7]}}, ir_i[7:0]} :
               opc == 5'b11000 ? sh :
               opc[1:0] == 2'b00 ? rn_o + sh :
               opc[1:0] == 2'b10 ? rn_o & sh : ~sh;
  assign wr_alu = alu_en_i && (opc == 5'b11010 || opc == 5'b11000 || (opc[4:2] == 3'b101 && opc[1:0] != 2'b01));
  assign wnum = lnk_en_i ? 3'd7 : opc == 5'b11010 ? ir_i[10:8] : ir_i[7:5];
  assign wdata = lnk_en_i ? {7'b0, pc_i} : ld_en_i ? ld_data_i : res;
  always_ff @(posedge clk) begin
    if (rst) {n_q, z_q, v_q} <= 3'b000;
    else if (alu_en_i && opc == 5'b10101)
      {n_q, z_q, v_q} <= {dif[15], dif == 16'h0, (rn_o[15] != sh[15]) && (dif[15] != rn_o[15])};
  end
  assign {n_o, z_o, v_o} = {n_q, z_q, v_q};
endmodule

module lab7bonus_cpu (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] mdata_i,
  output logic [8:0]  addr_o,
  output logic [1:0]  cmd_o,
  output logic [15:0] wdata_o,
  output logic        halted_o,
  output logic [15:0] r0_o,
  output logic [8:0]  pc_o
);
  localparam logic [1:0] M_NONE = 2'd0, M_READ = 2'd1, M_WRITE = 2'd2;
  typedef enum logic [3:0] {RST, IF1, IF2, UPC, DEC, EXE, RD1, RD2, WR, HALT} state_t;
  state_t      state_q, state_d;
  logic [8:0]  PC, pc_d, addr_q, addr_d, sx8, sx5;
  logic [15:0] ir_q, rn, rd;
  logic [2:0]  cond;
  logic        n, z, v, taken, ib, ibl, ibx, iblx, ild, ist;
  assign sx8 = {ir_q[7], ir_q[7:0]};
  assign sx5 = {{4{ir_q[4]}}, ir_q[4:0]};
  assign cond = ir_q[10:8];
  assign taken = cond == 3'd0 || (cond == 3'd1 && z) || (cond == 3'd2 && !z) ||
                 (cond == 3'd3 && (n ^ v)) || (cond == 3'd4 && ((n ^ v) || z));
  assign ib = ir_q[15:11] == 5'b00100;
  assign ibl = ir_q[15:11] == 5'b01011;
  assign ibx = ir_q[15:11] == 5'b01000;
  assign iblx = ir_q[15:11] == 5'b01010;
  assign ild = ir_q[15:11] == 5'b01100;
  assign ist = ir_q[15:11] == 5'b10000;
  lab7bonus_dp DP (
    .clk(clk), .rst(rst), .ir_i(ir_q), .alu_en_i(state_q == EXE), .ld_en_i(state_q == RD2),
    .lnk_en_i(state_q == EXE && (ibl || iblx)), .ld_data_i(mdata_i), .pc_i(PC),
    .rn_o(rn), .rd_o(rd), .r0_o(r0_o), .n_o(n), .z_o(z), .v_o(v)
  );
  always_comb begin
    state_d = state_q;
    pc_d = PC;
    addr_d = addr_q;
    cmd_o = M_NONE;
    addr_o = PC;
    case (state_q)
      RST: state_d = IF1;
      IF1: begin state_d = IF2; cmd_o = M_READ; end
      IF2: begin state_d = UPC; cmd_o = M_READ; end
      UPC: begin state_d = DEC; pc_d = PC + 9'd1; end
      DEC: state_d = ir_q[15:13] == 3'b111 ? HALT : EXE;
      EXE: begin
        state_d = ild ? RD1 : ist ? WR : IF1;
        addr_d = rn[8:0] + sx5;
        pc_d = (ib && taken) || ibl ? PC + sx8 : ibx || iblx ? rd[8:0] : PC;
      end
      RD1, RD2: begin state_d = state_q == RD1 ? RD2 : IF1; cmd_o = M_READ; addr_o = addr_q; end
      WR: begin state_d = IF1; cmd_o = M_WRITE; addr_o = addr_q; end
      default: state_d = HALT;
    endcase
    if (rst) cmd_o = M_NONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RST;
      PC <= '0;
      ir_q <= '0;
      addr_q <= '0;
    end else begin
      state_q <= state_d;
      PC <= pc_d;
      ir_q <= state_q == IF2 ? mdata_i : ir_q;
      addr_q <= addr_d;
    end
  end
  assign wdata_o = rd;
  assign halted_o = state_q == HALT;
  assign pc_o = PC;
endmodule

module lab7bonus_ram #(parameter int ADDR_W = 8) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [15:0]       din_i,
  output logic [15:0]       dout_o
);
  logic [15:0] mem [0:2**ADDR_W-1];
  logic [15:0] dout_q;
  always_ff @(posedge clk) begin
    if (we_i) mem[addr_i] <= din_i;
    dout_q <= mem[addr_i];
  end
  assign dout_o = dout_q;
endmodule

module lab7bonus_top #(parameter int ADDR_W = 8) (
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [9:0] LEDR,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5
);
  localparam logic [1:0] M_READ = 2'd1, M_WRITE = 2'd2;
  logic        clk, rst, halted, unused;
  logic [8:0]  addr, pc;
  logic [1:0]  cmd;
  logic [15:0] dout, mdata, wdata, r0;
  logic [7:0]  led_q;
  assign clk = CLOCK_50;
  assign rst = ~KEY[1];
  lab7bonus_cpu CPU (
    .clk(clk), .rst(rst), .mdata_i(mdata), .addr_o(addr), .cmd_o(cmd), .wdata_o(wdata),
    .halted_o(halted), .r0_o(r0), .pc_o(pc)
  );
  lab7bonus_ram #(.ADDR_W(ADDR_W)) MEM (
    .clk(clk), .we_i(cmd == M_WRITE && !addr[8]), .addr_i(addr[ADDR_W-1:0]), .din_i(wdata), .dout_o(dout)
  );
  assign mdata = cmd != M_READ ? 16'h0 : !addr[8] ? dout : addr == 9'h140 ? {8'h00, SW[7:0]} : 16'h0;
  always_ff @(posedge clk) begin
    if (rst) led_q <= '0;
    else if (cmd == M_WRITE && addr == 9'h100) led_q <= wdata[7:0];
  end
  assign LEDR = {1'b0, halted, led_q};
`ifdef HEX_DEBUG_EN
  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  assign HEX0 = rst ? 7'h7F : SEG[r0[3:0]];
  assign HEX1 = rst ? 7'h7F : SEG[r0[7:4]];
  assign HEX2 = rst ? 7'h7F : SEG[r0[11:8]];
  assign HEX3 = rst ? 7'h7F : SEG[r0[15:12]];
  assign HEX4 = rst ? 7'h7F : SEG[pc[3:0]];
  assign HEX5 = rst ? 7'h7F : SEG[pc[7:4]];
  assign unused = ^{KEY[3:2], KEY[0], SW[9:8], pc[8]};
`else
  assign {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} = {6{7'h7F}};
  assign unused = ^{KEY[3:2], KEY[0], SW[9:8], r0, pc};
`endif
endmodule

// File: tb/tb_lab7bonus_top.sv
// tb_lab7bonus_top: runs small programs to HALT and checks registers, flags, PC, LEDs and RAM against a queue of expectations.
module tb_lab7bonus_top;
  logic       CLOCK_50 = 1'b0;
  logic [3:0] KEY = 4'hF;
  logic [9:0] SW = '0;
  logic [9:0] LEDR;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  always #5 CLOCK_50 = ~CLOCK_50;
  lab7bonus_top dut (
    .CLOCK_50(CLOCK_50), .KEY(KEY), .SW(SW), .LEDR(LEDR),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
  );
  typedef struct packed {logic [3:0] sel; logic [7:0] addr; logic [15:0] exp;} exp_t;
  localparam logic [3:0] S_PC = 4'd8, S_N = 4'd9, S_Z = 4'd10, S_V = 4'd11, S_LED = 4'd12, S_MEM = 4'd13,
                         S_HEX0 = 4'd14, S_HEX5 = 4'd15;
  exp_t        sb[$];
  logic [15:0] img[$];
  int          total = 0, bad = 0;
  string       tname;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] obs(input exp_t e);
    case (e.sel)
      4'd0: return dut.CPU.DP.REGFILE.R0;
      4'd1: return dut.CPU.DP.REGFILE.R1;
      4'd2: return dut.CPU.DP.REGFILE.R2;
      4'd3: return dut.CPU.DP.REGFILE.R3;
      4'd4: return dut.CPU.DP.REGFILE.R4;
      4'd5: return dut.CPU.DP.REGFILE.R5;
      4'd6: return dut.CPU.DP.REGFILE.R6;
      4'd7: return dut.CPU.DP.REGFILE.R7;
      S_PC: return {7'b0, dut.CPU.PC};
      S_N: return {15'b0, dut.CPU.DP.n_q};
      S_Z: return {15'b0, dut.CPU.DP.z_q};
      S_V: return {15'b0, dut.CPU.DP.v_q};
      S_LED: return {6'b0, LEDR};
      S_MEM: return dut.MEM.mem[e.addr];
      S_HEX0: return {9'b0, HEX0};
      default: return {9'b0, HEX5};
    endcase
  endfunction
  task automatic want(input logic [3:0] sel, input logic [15:0] v);
    sb.push_back({sel, 8'h00, v});
  endtask
  task automatic want_mem(input logic [7:0] a, input logic [15:0] v);
    sb.push_back({S_MEM, a, v});
  endtask
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("%s.sel%0d.a%0h", tname, e.sel, e.addr), obs(e), e.exp);
    end
  endtask
  task automatic load();
    for (int i = 0; i < 256; i++) dut.MEM.mem[i] = i < img.size() ? img[i] : 16'h0000;
  endtask
  task automatic pulse_reset();
    KEY[1] = 1'b0;
    @(negedge CLOCK_50);
    KEY[1] = 1'b1;
  endtask
  task automatic wait_halt();
    for (int c = 0; c < 500 && !LEDR[8]; c++) @(negedge CLOCK_50);
    check({tname, ".halted"}, {15'b0, LEDR[8]}, 16'h0001);
  endtask
  task automatic expect_t1();
    want(4'd0, 16'h0002); want(4'd1, 16'h0003); want(4'd2, 16'h0000); want(4'd4, 16'h0000);
    want(S_PC, 16'h0007); want(S_LED, 16'h0100);
  endtask
  initial begin
    int   rises;
    logic prev;
    tname = "reset";
    KEY[1] = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    for (int r = 0; r < 8; r++) want(r[3:0], 16'h0000);
    want(S_PC, 16'h0000); want(S_LED, 16'h0000); want(S_N, 16'h0); want(S_Z, 16'h0); want(S_V, 16'h0);
    want(S_HEX0, 16'h007F); want(S_HEX5, 16'h007F);
    drain();
    tname = "branch_skip";
    img = '{16'hD002, 16'hD103, 16'h2003, 16'hA140, 16'h0000, 16'hD442, 16'hE000, 16'h0000};
    load();
    pulse_reset();
    wait_halt();
    expect_t1();
    drain();
    rises = 0;
    prev = LEDR[8];
    repeat (20) begin
      @(negedge CLOCK_50);
      if (LEDR[8] && !prev) rises++;
      prev = LEDR[8];
    end
    tname = "halt_hold";
    check({tname, ".rises"}, rises[15:0], 16'h0000);
    want(S_PC, 16'h0007); want(S_LED, 16'h0100); want(S_HEX0, 16'h007F);
    drain();
    tname = "cmp_blt";
    img = '{16'hD0FF, 16'hD101, 16'hA801, 16'h2301, 16'hD305, 16'hE000};
    load();
    pulse_reset();
    wait_halt();
    want(4'd0, 16'hFFFF); want(4'd1, 16'h0001); want(4'd3, 16'h0000);
    want(S_N, 16'h1); want(S_V, 16'h0); want(S_Z, 16'h0); want(S_PC, 16'h0006);
    drain();
    tname = "alu_shift";
    img = '{16'hD003, 16'h652F, 16'hA059, 16'hB860, 16'hC091, 16'hB0C9, 16'hE000};
    load();
    dut.MEM.mem[15] = 16'h8001;
    pulse_reset();
    wait_halt();
    want(4'd1, 16'h8001); want(4'd2, 16'hC003); want(4'd3, 16'hFFFC); want(4'd4, 16'h4000);
    want(4'd6, 16'h0002); want(S_N, 16'h0); want(S_PC, 16'h0007);
    drain();
    tname = "io";
    SW = 10'h35A;
    img = '{16'hD150, 16'hC029, 16'hC029, 16'hD240, 16'hC04A, 16'hC04A, 16'h6100, 16'h8200, 16'hE000};
    load();
    pulse_reset();
    wait_halt();
    want(4'd0, 16'h005A); want(4'd1, 16'h0140); want(4'd2, 16'h0100); want(S_LED, 16'h015A);
    want_mem(8'h00, 16'hD150); want_mem(8'h40, 16'h0000); want(S_PC, 16'h0009);
    drain();
    tname = "ram_ldst";
    img = '{16'h650E, 16'hD110, 16'h8102, 16'h61A2, 16'hE000};
    load();
    dut.MEM.mem[14] = 16'h1234;
    pulse_reset();
    wait_halt();
    want_mem(8'h12, 16'h1234); want(4'd0, 16'h1234); want(4'd5, 16'h1234);
    want(S_LED, 16'h0100); want(S_PC, 16'h0005);
    drain();
    tname = "bl_bx";
    img = '{16'hD001, 16'hA800, 16'h2101, 16'hD309, 16'h2201, 16'h5F02, 16'hD407, 16'hE000, 16'hD211, 16'h40E0};
    load();
    pulse_reset();
    wait_halt();
    want(4'd3, 16'h0000); want(4'd2, 16'h0011); want(4'd7, 16'h0006); want(4'd4, 16'h0007);
    want(S_Z, 16'h1); want(S_N, 16'h0); want(S_PC, 16'h0008);
    drain();
    tname = "mid_reset";
    img = '{16'hD002, 16'hD103, 16'h2003, 16'hA140, 16'h0000, 16'hD442, 16'hE000, 16'h0000};
    load();
    pulse_reset();
    repeat (12) @(negedge CLOCK_50);
    KEY[1] = 1'b0;
    @(negedge CLOCK_50);
    want(S_PC, 16'h0000); want(4'd0, 16'h0000); want(4'd1, 16'h0000); want(S_LED, 16'h0000);
    drain();
    KEY[1] = 1'b1;
    tname = "rerun";
    wait_halt();
    expect_t1();
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
